// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared types and helpers for mem_bank
package mem_bank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Even-parity bit: makes the total count of ones in {word, bit} even.
   function automatic logic parity_even(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for button-level inputs
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - DEPTH x WIDTH register file, edge-qualified write, sequenced clear
// Optional per-word even parity with registered parity_err under MEM_BANK_PARITY_EN.
module mem_bank
   import mem_bank_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  data,
   input  logic              store,
   input  logic [ADDR_W-1:0] addr,
   input  logic              clear,
   output logic [WIDTH-1:0]  memory,
`ifdef MEM_BANK_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   logic [WIDTH-1:0]  mem [DEPTH];
   state_t            state, state_nx;
   logic [ADDR_W-1:0] count;
   logic              store_rise;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;

   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (store),
      .rise  (store_rise)
   );

   // The clear sweep borrows the single write port; user writes only happen in IDLE.
   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_addr  = addr;
      wr_data  = data;
      case (state)
         IDLE: begin
            if (clear)           state_nx = CLEAR;
            else if (store_rise) wr_en    = 1'b1;
         end
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = count;
            wr_data = '0;
            if (count == ADDR_W'(DEPTH - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         memory <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nx;
         count <= (state == CLEAR) ? count + 1'b1 : '0;
         if (wr_en) mem[wr_addr] <= wr_data;
         memory <= (wr_en && wr_addr == addr) ? wr_data : mem[addr];
      end
   end

   assign busy = (state == CLEAR);

`ifdef MEM_BANK_PARITY_EN
   logic par [DEPTH];
   logic wr_par;

   assign wr_par = (state == CLEAR) ? 1'b0 : parity_even(32'(data));

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
      end else begin
         if (wr_en) par[wr_addr] <= wr_par;
         parity_err <= (wr_en && wr_addr == addr)
                       ? (^wr_data ^ wr_par)
                       : (^mem[addr] ^ par[addr]);
      end
   end
`endif

endmodule
